// File: rtl/edge_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : edge_sched_pkg
// Brief    : Shared edge-mode encodings and output-register states.
// Revision : 1.0
// ============================================================================
package edge_sched_pkg;

  localparam logic [1:0] MODE_OFF   = 2'b00;
  localparam logic [1:0] MODE_RISE  = 2'b01;
  localparam logic [1:0] MODE_FALL  = 2'b10;
  localparam logic [1:0] MODE_BOTH  = 2'b11;
  localparam logic [1:0] RESET_MODE = MODE_RISE;

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_HOLD  = 1'b1
  } out_state_t;

endpackage
`default_nettype wire

// File: rtl/edge_detect_cell.sv
`default_nettype none
// ============================================================================
// Module   : edge_detect_cell
// Brief    : One channel: edge detector, mode qualification, pending slot
//            (pend/pol) and sticky overflow flag.
// Revision : 1.0
// ============================================================================
module edge_detect_cell
  import edge_sched_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       primed,
  input  logic       sig,
  input  logic       cfg_we,
  input  logic [1:0] cfg_mode,
  input  logic       grant,
  input  logic       ovf_clr,
  output logic       pend,
  output logic       pol,
  output logic       ovf
);

  logic       prev_q, prev_d;
  logic [1:0] mode_q, mode_d;
  logic       pend_q, pend_d;
  logic       pol_q,  pol_d;
  logic       ovf_q,  ovf_d;
  logic       rise, fall, qual;

  always_comb begin
    rise   = primed & sig & ~prev_q;
    fall   = primed & ~sig & prev_q;
    qual   = (rise & mode_q[0]) | (fall & mode_q[1]);
    prev_d = sig;
    mode_d = cfg_we ? cfg_mode : mode_q;
    pend_d = pend_q & ~grant;
    pol_d  = pol_q;
    ovf_d  = ovf_q & ~ovf_clr;
    // A slot being granted this cycle is free to take the new edge.
    if (qual) begin
      if (pend_q && !grant) begin
        ovf_d = 1'b1;
      end else begin
        pend_d = 1'b1;
        pol_d  = rise;
      end
    end
    if (cfg_we && cfg_mode == MODE_OFF) begin
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= 1'b0;
      mode_q <= RESET_MODE;
      pend_q <= 1'b0;
      pol_q  <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      prev_q <= prev_d;
      mode_q <= mode_d;
      pend_q <= pend_d;
      pol_q  <= pol_d;
      ovf_q  <= ovf_d;
    end
  end

  assign pend = pend_q;
  assign pol  = pol_q;
  assign ovf  = ovf_q;

endmodule
`default_nettype wire

// File: rtl/edge_event_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : edge_event_scheduler
// Brief    : Per-channel edge detection with a round-robin arbitrated
//            valid/ready event port. Define EDGE_SCHED_SYNC_EN to insert a
//            2-flop synchronizer on every sig_in bit.
// Revision : 1.0
// ============================================================================
module edge_event_scheduler
  import edge_sched_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] sig_in,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [1:0]        cfg_mode,
  output logic              ev_valid,
  input  logic              ev_ready,
  output logic [CH_W-1:0]   ev_ch,
  output logic              ev_rise,
  output logic [NUM_CH-1:0] ovf,
  input  logic              ovf_clr
);

  logic [NUM_CH-1:0] sig_det;
  logic [NUM_CH-1:0] pend, pol, grant;
  logic              primed_q, primed_d;
  out_state_t        state_q, state_d;
  logic [CH_W-1:0]   ev_ch_q, ev_ch_d;
  logic              ev_rise_q, ev_rise_d;
  logic [CH_W-1:0]   ptr_q, ptr_d;
  logic [CH_W-1:0]   cand, sel;
  logic              load, found;

`ifdef EDGE_SCHED_SYNC_EN
  logic [NUM_CH-1:0] sync1_q, sync1_d, sync2_q, sync2_d;

  always_comb begin
    sync1_d = sig_in;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign sig_det = sync2_q;
`else
  assign sig_det = sig_in;
`endif

  generate
    for (genvar g = 0; g < NUM_CH; g++) begin : g_cell
      edge_detect_cell u_cell (
        .clk      (clk),
        .rst      (rst),
        .primed   (primed_q),
        .sig      (sig_det[g]),
        .cfg_we   (cfg_we && (int'(cfg_ch) == g)),
        .cfg_mode (cfg_mode),
        .grant    (grant[g]),
        .ovf_clr  (ovf_clr),
        .pend     (pend[g]),
        .pol      (pol[g]),
        .ovf      (ovf[g])
      );
    end
  endgenerate

  // Round-robin search starts just after the last granted channel.
  always_comb begin
    load  = (state_q == ST_EMPTY) || ev_ready;
    found = 1'b0;
    sel   = '0;
    cand  = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      cand = CH_W'((int'(ptr_q) + i) % NUM_CH);
      if (!found && pend[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end

    primed_d  = 1'b1;
    state_d   = state_q;
    ev_ch_d   = ev_ch_q;
    ev_rise_d = ev_rise_q;
    ptr_d     = ptr_q;
    grant     = '0;
    if (load) begin
      state_d = found ? ST_HOLD : ST_EMPTY;
      if (found) begin
        grant[sel] = 1'b1;
        ev_ch_d    = sel;
        ev_rise_d  = pol[sel];
        ptr_d      = sel;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      primed_q  <= 1'b0;
      state_q   <= ST_EMPTY;
      ev_ch_q   <= '0;
      ev_rise_q <= 1'b0;
      ptr_q     <= CH_W'(NUM_CH - 1);
    end else begin
      primed_q  <= primed_d;
      state_q   <= state_d;
      ev_ch_q   <= ev_ch_d;
      ev_rise_q <= ev_rise_d;
      ptr_q     <= ptr_d;
    end
  end

  assign ev_valid = (state_q == ST_HOLD);
  assign ev_ch    = ev_ch_q;
  assign ev_rise  = ev_rise_q;

endmodule
`default_nettype wire

// File: tb/tb_edge_event_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_edge_event_scheduler
// Brief    : Directed scenarios plus randomized traffic, every cycle compared
//            against a behavioural model of the scheduler.
// Revision : 1.0
// ============================================================================
module tb_edge_event_scheduler;

  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NUM_CH-1:0] sig_in = '0;
  logic              cfg_we = 1'b0;
  logic [CH_W-1:0]   cfg_ch = '0;
  logic [1:0]        cfg_mode = 2'b00;
  logic              ev_valid;
  logic              ev_ready = 1'b0;
  logic [CH_W-1:0]   ev_ch;
  logic              ev_rise;
  logic [NUM_CH-1:0] ovf;
  logic              ovf_clr = 1'b0;

  int check_cnt = 0;
  int fail_cnt  = 0;

  always #5 clk = ~clk;

  edge_event_scheduler #(.NUM_CH(NUM_CH), .CH_W(CH_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .sig_in   (sig_in),
    .cfg_we   (cfg_we),
    .cfg_ch   (cfg_ch),
    .cfg_mode (cfg_mode),
    .ev_valid (ev_valid),
    .ev_ready (ev_ready),
    .ev_ch    (ev_ch),
    .ev_rise  (ev_rise),
    .ovf      (ovf),
    .ovf_clr  (ovf_clr)
  );

  // Reference model state
  bit [1:0] m_mode [NUM_CH];
  bit       m_pend [NUM_CH];
  bit       m_pol  [NUM_CH];
  bit       m_ovf  [NUM_CH];
  bit       m_prev [NUM_CH];
  bit       m_primed;
  bit       m_valid;
  int       m_ch;
  bit       m_rise;
  int       m_ptr;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    if (obs !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [NUM_CH-1:0] m_ovf_vec();
    logic [NUM_CH-1:0] v;
    for (int c = 0; c < NUM_CH; c++) v[c] = m_ovf[c];
    return v;
  endfunction

  // Advances the model by one clock using the inputs currently applied.
  task automatic model_step();
    int  g;
    bit  r, f, q;
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        m_mode[c] = 2'b01; m_pend[c] = 0; m_pol[c] = 0; m_ovf[c] = 0; m_prev[c] = 0;
      end
      m_primed = 0; m_valid = 0; m_ch = 0; m_rise = 0; m_ptr = NUM_CH - 1;
      return;
    end
    g = -1;
    if (!m_valid || ev_ready) begin
      for (int i = 1; i <= NUM_CH; i++)
        if (g < 0 && m_pend[(m_ptr + i) % NUM_CH]) g = (m_ptr + i) % NUM_CH;
      if (g >= 0) begin
        m_valid = 1; m_ch = g; m_rise = m_pol[g]; m_ptr = g;
      end else begin
        m_valid = 0;
      end
    end
    for (int c = 0; c < NUM_CH; c++) begin
      r = m_primed && sig_in[c] && !m_prev[c];
      f = m_primed && !sig_in[c] && m_prev[c];
      q = (r && (m_mode[c] == 2'b01 || m_mode[c] == 2'b11)) ||
          (f && (m_mode[c] == 2'b10 || m_mode[c] == 2'b11));
      if (g == c) m_pend[c] = 0;
      if (ovf_clr) m_ovf[c] = 0;
      if (q) begin
        if (m_pend[c]) m_ovf[c] = 1;
        else begin m_pend[c] = 1; m_pol[c] = r; end
      end
      if (cfg_we && int'(cfg_ch) == c) begin
        if (cfg_mode == 2'b00) m_pend[c] = 0;
        m_mode[c] = cfg_mode;
      end
      m_prev[c] = sig_in[c];
    end
    m_primed = 1;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_eq("m_valid", 32'(ev_valid), 32'(m_valid));
    if (m_valid) begin
      check_eq("m_ch", 32'(ev_ch), 32'(m_ch));
      check_eq("m_rise", 32'(ev_rise), 32'(m_rise));
    end
    check_eq("m_ovf", 32'(ovf), 32'(m_ovf_vec()));
  endtask

  task automatic cfg_write(input int ch, input logic [1:0] mode);
    cfg_we = 1'b1; cfg_ch = CH_W'(ch); cfg_mode = mode;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  int c0, c1;

  initial begin
    // Reset and priming
    rst = 1'b1; tick(); tick();
    check_eq("rst_valid", 32'(ev_valid), 32'd0);
    check_eq("rst_ch", 32'(ev_ch), 32'd0);
    check_eq("rst_rise", 32'(ev_rise), 32'd0);
    check_eq("rst_ovf", 32'(ovf), 32'd0);
    rst = 1'b0; tick();

    // Rise on ch0, default mode
    ev_ready = 1'b1;
    sig_in = 4'b0001; tick();
    check_eq("r0_lat", 32'(ev_valid), 32'd0);
    tick();
    check_eq("r0_valid", 32'(ev_valid), 32'd1);
    check_eq("r0_ch", 32'(ev_ch), 32'd0);
    check_eq("r0_rise", 32'(ev_rise), 32'd1);
    tick();
    check_eq("r0_once", 32'(ev_valid), 32'd0);
    sig_in = 4'b0000; tick(); tick();
    check_eq("r0_nofall", 32'(ev_valid), 32'd0);

    // Simultaneous rise on all channels, mode both
    do_reset();
    for (int c = 0; c < NUM_CH; c++) cfg_write(c, 2'b11);
    ev_ready = 1'b1;
    sig_in = 4'b1111; tick();
    for (int c = 0; c < NUM_CH; c++) begin
      tick();
      check_eq("all_valid", 32'(ev_valid), 32'd1);
      check_eq("all_ch", 32'(ev_ch), 32'(c));
      check_eq("all_rise", 32'(ev_rise), 32'd1);
    end
    tick();
    check_eq("all_idle", 32'(ev_valid), 32'd0);
    sig_in = 4'b0101; tick(); tick();
    check_eq("fall1_ch", 32'(ev_ch), 32'd1);
    check_eq("fall1_rise", 32'(ev_rise), 32'd0);
    tick();
    check_eq("fall3_ch", 32'(ev_ch), 32'd3);
    check_eq("fall3_rise", 32'(ev_rise), 32'd0);

    // Overflow with the port stalled
    sig_in = 4'b0000; tick(); tick(); tick(); tick();
    ev_ready = 1'b0;
    sig_in = 4'b0100; tick();
    sig_in = 4'b0000; tick();
    sig_in = 4'b0100; tick();
    sig_in = 4'b0000; tick();
    check_eq("ovf_valid", 32'(ev_valid), 32'd1);
    check_eq("ovf_ch", 32'(ev_ch), 32'd2);
    check_eq("ovf_rise", 32'(ev_rise), 32'd1);
    check_eq("ovf_flag", 32'(ovf), 32'h4);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    check_eq("ovf_clr", 32'(ovf), 32'h0);
    ev_ready = 1'b1; tick();
    check_eq("ovf_next_ch", 32'(ev_ch), 32'd2);
    check_eq("ovf_next_rise", 32'(ev_rise), 32'd0);
    tick(); tick();

    // Fairness between ch0 and ch1
    cfg_write(0, 2'b01); cfg_write(1, 2'b01);
    c0 = 0; c1 = 0;
    for (int i = 0; i < 8; i++) begin
      sig_in[1:0] = ~sig_in[1:0];
      tick();
      if (ev_valid && ev_ch == 2'd0) c0++;
      if (ev_valid && ev_ch == 2'd1) c1++;
    end
    check_eq("fair_c0", 32'(c0 >= 3), 32'd1);
    check_eq("fair_c1", 32'(c1 >= 3), 32'd1);

    // Config gating on ch3
    sig_in = 4'b0000; tick(); tick(); tick(); tick();
    cfg_write(3, 2'b01);
    ev_ready = 1'b0;
    sig_in = 4'b0001; tick(); tick();
    sig_in = 4'b1001; tick();
    cfg_write(3, 2'b00);
    check_eq("gate_hold_ch", 32'(ev_ch), 32'd0);
    ev_ready = 1'b1; tick();
    check_eq("gate_drop1", 32'(ev_valid), 32'd0);
    tick();
    check_eq("gate_drop2", 32'(ev_valid), 32'd0);
    sig_in = 4'b0001; tick();
    cfg_write(3, 2'b10);
    sig_in = 4'b1001; tick();
    sig_in = 4'b0001; tick(); tick();
    check_eq("gate_fall_v", 32'(ev_valid), 32'd1);
    check_eq("gate_fall_ch", 32'(ev_ch), 32'd3);
    check_eq("gate_fall_r", 32'(ev_rise), 32'd0);
    tick();
    check_eq("gate_once", 32'(ev_valid), 32'd0);

    // Reset mid-operation
    ev_ready = 1'b0;
    sig_in = 4'b0000; tick(); tick();
    sig_in = 4'b0001; tick(); tick();
    check_eq("mid_valid", 32'(ev_valid), 32'd1);
    rst = 1'b1; sig_in = 4'b1111; tick();
    check_eq("mid_rst_v", 32'(ev_valid), 32'd0);
    check_eq("mid_rst_ovf", 32'(ovf), 32'd0);
    rst = 1'b0; ev_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("mid_noev", 32'(ev_valid), 32'd0);
    end

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rst      = ($urandom_range(0, 249) == 0);
      sig_in   = sig_in ^ (4'($urandom) & 4'($urandom));
      ev_ready = ($urandom_range(0, 3) != 0);
      cfg_we   = ($urandom_range(0, 7) == 0);
      cfg_ch   = 2'($urandom);
      cfg_mode = 2'($urandom);
      ovf_clr  = ($urandom_range(0, 15) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", check_cnt, fail_cnt);
    $finish;
  end

endmodule
`default_nettype wire
